csr_shadowed: RTL

Parametrised successor to the accelerator control/status register file, sitting between the host command decoder (UART/AXI-lite bridge) and the GEMM core. It adds shadow/active double-buffering of tile configuration, so host writes during a running tile never disturb the core. It also adds sticky write-1-to-clear status with a maskable interrupt, atomic snapshot of N_PERF performance counters, and a registered read path with valid/error flags.

---
 rtl/csr_shadowed_pkg.sv | 56 +++++
 rtl/csr_perf_snap.sv | 43 ++++
 rtl/csr_shadowed.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_shadowed_pkg.sv
// Shared constants and types for the shadowed accelerator CSR file.
package csr_shadowed_pkg;

  // Width of the dimension/index fields carried in cfg_t
  localparam int CFG_DIM_W = 16;

  // Byte addresses of the register map
  localparam int A_CTRL      = 'h00;
  localparam int A_M         = 'h04;
  localparam int A_N         = 'h08;
  localparam int A_K         = 'h0C;
  localparam int A_TM        = 'h10;
  localparam int A_TN        = 'h14;
  localparam int A_TK        = 'h18;
  localparam int A_M_IDX     = 'h1C;
  localparam int A_N_IDX     = 'h20;
  localparam int A_K_IDX     = 'h24;
  localparam int A_BUFF      = 'h28;
  localparam int A_SA        = 'h2C;
  localparam int A_SW        = 'h30;
  localparam int A_UART_LEN  = 'h34;
  localparam int A_CRC_EN    = 'h38;
  localparam int A_STATUS    = 'h3C;
  localparam int A_IRQ_MASK  = 'h40;
  localparam int A_PERF_SNAP = 'h44;
  localparam int A_PERF0     = 'h48;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_CRC_ERR   = 2;
  localparam int ST_ILLEGAL   = 3;
  localparam int ST_START_ERR = 4;

  // Tile configuration, used for both the host-visible shadow and the active copy
  typedef struct packed {
    logic [CFG_DIM_W-1:0] m;
    logic [CFG_DIM_W-1:0] n;
    logic [CFG_DIM_W-1:0] k;
    logic [CFG_DIM_W-1:0] tm;
    logic [CFG_DIM_W-1:0] tn;
    logic [CFG_DIM_W-1:0] tk;
    logic [CFG_DIM_W-1:0] m_idx;
    logic [CFG_DIM_W-1:0] n_idx;
    logic [CFG_DIM_W-1:0] k_idx;
    logic [3:0]           bank_sel;
    logic [31:0]          sa;
    logic [31:0]          sw;
  } cfg_t;

endpackage

// File: rtl/csr_perf_snap.sv
// Snapshot bank for the performance counters: captures every live counter at
// once so the host reads a coherent set, and muxes one snapshot out by index.
module csr_perf_snap
  import csr_shadowed_pkg::*;
#(
  parameter int N_PERF = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snap_en,
  input  logic [32*N_PERF-1:0] perf_cnt,
  input  logic [3:0]          rd_idx,
  output logic [31:0]         rd_data
);

  logic [31:0] snap_q [N_PERF];
  logic [31:0] snap_d [N_PERF];

  // Capture all counters together on a snapshot request, otherwise hold
  always_comb begin
    for (int i = 0; i < N_PERF; i++) begin
      snap_d[i] = snap_en ? perf_cnt[32*i +: 32] : snap_q[i];
    end
  end

  // Snapshot storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PERF; i++) snap_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PERF; i++) snap_q[i] <= snap_d[i];
    end
  end

  // Indexed read of the snapshot; an index past the bank reads zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_PERF; i++) begin
      if (rd_idx == 4'(i)) rd_data = snap_q[i];
    end
  end

endmodule

// File: rtl/csr_shadowed.sv
// Accelerator CSR file with shadow/active tile configuration, sticky W1C
// status with maskable interrupt, perf counter snapshots and a registered
// read port. DIM_W must match the field width of cfg_t in the package.
module csr_shadowed
  import csr_shadowed_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIM_W  = CFG_DIM_W,
  parameter int N_PERF = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 csr_wen,
  input  logic                 csr_ren,
  input  logic [ADDR_W-1:0]    csr_addr,
  input  logic [31:0]          csr_wdata,
  output logic [31:0]          csr_rdata,
  output logic                 csr_rvalid,
  output logic                 csr_err,
  input  logic                 core_busy,
  input  logic                 core_done_tile_pulse,
  input  logic                 rx_crc_error,
  input  logic                 rx_illegal_cmd,
  input  logic [32*N_PERF-1:0] perf_cnt,
  output logic                 start_pulse,
  output logic                 abort_pulse,
  output logic                 irq,
  output logic [DIM_W-1:0]     cfg_M,
  output logic [DIM_W-1:0]     cfg_N,
  output logic [DIM_W-1:0]     cfg_K,
  output logic [DIM_W-1:0]     cfg_Tm,
  output logic [DIM_W-1:0]     cfg_Tn,
  output logic [DIM_W-1:0]     cfg_Tk,
  output logic [DIM_W-1:0]     cfg_m_idx,
  output logic [DIM_W-1:0]     cfg_n_idx,
  output logic [DIM_W-1:0]     cfg_k_idx,
  output logic [3:0]           cfg_bank_sel,
  output logic [31:0]          cfg_Sa,
  output logic [31:0]          cfg_Sw,
  output logic [15:0]          uart_len_max,
  output logic                 uart_crc_en
);

  cfg_t        shadow_q, shadow_d, active_q, active_d;
  logic        irq_en_q, irq_en_d;
  logic [4:1]  mask_q, mask_d, sticky_q, sticky_d;
  logic [15:0] uart_len_q, uart_len_d;
  logic        crc_en_q, crc_en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic        start_q, start_d, abort_q, abort_d, irq_q, irq_d;

  int          addr_i;
  logic        aligned, mapped, perf_hit, snap_en, start_err;
  logic [3:0]  perf_idx;
  logic [4:1]  clr;
  logic [31:0] rd_mux, perf_rdata;

  csr_perf_snap #(.N_PERF(N_PERF)) u_perf_snap (
    .clk      (clk),
    .rst_n    (rst_n),
    .snap_en  (snap_en),
    .perf_cnt (perf_cnt),
    .rd_idx   (perf_idx),
    .rd_data  (perf_rdata)
  );

  // Address decode: alignment, perf window hit and overall mapped check
  always_comb begin
    addr_i   = int'(csr_addr);
    aligned  = (csr_addr[1:0] == 2'b00);
    perf_hit = 1'b0;
    perf_idx = '0;
    for (int i = 0; i < N_PERF; i++) begin
      if (addr_i == A_PERF0 + 4*i) begin
        perf_hit = 1'b1;
        perf_idx = 4'(i);
      end
    end
    mapped = aligned && ((addr_i <= A_PERF_SNAP) || perf_hit);
  end

  // Read data selection; shadows are returned, never the active copy
  always_comb begin
    rd_mux = '0;
    case (addr_i)
      A_CTRL:     rd_mux = {29'b0, irq_en_q, 2'b00};
      A_M:        rd_mux = 32'(shadow_q.m);
      A_N:        rd_mux = 32'(shadow_q.n);
      A_K:        rd_mux = 32'(shadow_q.k);
      A_TM:       rd_mux = 32'(shadow_q.tm);
      A_TN:       rd_mux = 32'(shadow_q.tn);
      A_TK:       rd_mux = 32'(shadow_q.tk);
      A_M_IDX:    rd_mux = 32'(shadow_q.m_idx);
      A_N_IDX:    rd_mux = 32'(shadow_q.n_idx);
      A_K_IDX:    rd_mux = 32'(shadow_q.k_idx);
      A_BUFF:     rd_mux = 32'(shadow_q.bank_sel);
      A_SA:       rd_mux = shadow_q.sa;
      A_SW:       rd_mux = shadow_q.sw;
      A_UART_LEN: rd_mux = 32'(uart_len_q);
      A_CRC_EN:   rd_mux = 32'(crc_en_q);
      A_STATUS:   rd_mux = {27'b0, sticky_q, core_busy};
      A_IRQ_MASK: rd_mux = {27'b0, mask_q, 1'b0};
      default:    rd_mux = perf_hit ? perf_rdata : 32'h0;
    endcase
  end

  // Next-state for writes, commands, sticky status, irq and the read port
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    irq_en_d   = irq_en_q;
    mask_d     = mask_q;
    uart_len_d = uart_len_q;
    crc_en_d   = crc_en_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = (csr_wen | csr_ren) & ~mapped;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    snap_en    = 1'b0;
    start_err  = 1'b0;
    clr        = '0;
    irq_d      = irq_en_q & |(sticky_q & mask_q);
    if (csr_wen && mapped) begin
      case (addr_i)
        A_CTRL: begin
          irq_en_d = csr_wdata[CTRL_IRQ_EN];
          if (csr_wdata[CTRL_ABORT]) begin
            abort_d = 1'b1;
          end else if (csr_wdata[CTRL_START]) begin
            if (core_busy) begin
              start_err = 1'b1;
            end else begin
              start_d  = 1'b1;
              active_d = shadow_q;
            end
          end
        end
        A_M:         shadow_d.m        = csr_wdata[DIM_W-1:0];
        A_N:         shadow_d.n        = csr_wdata[DIM_W-1:0];
        A_K:         shadow_d.k        = csr_wdata[DIM_W-1:0];
        A_TM:        shadow_d.tm       = csr_wdata[DIM_W-1:0];
        A_TN:        shadow_d.tn       = csr_wdata[DIM_W-1:0];
        A_TK:        shadow_d.tk       = csr_wdata[DIM_W-1:0];
        A_M_IDX:     shadow_d.m_idx    = csr_wdata[DIM_W-1:0];
        A_N_IDX:     shadow_d.n_idx    = csr_wdata[DIM_W-1:0];
        A_K_IDX:     shadow_d.k_idx    = csr_wdata[DIM_W-1:0];
        A_BUFF:      shadow_d.bank_sel = csr_wdata[3:0];
        A_SA:        shadow_d.sa       = csr_wdata;
        A_SW:        shadow_d.sw       = csr_wdata;
        A_UART_LEN:  uart_len_d        = csr_wdata[15:0];
        A_CRC_EN:    crc_en_d          = csr_wdata[0];
        A_STATUS:    clr               = csr_wdata[ST_START_ERR:ST_DONE];
        A_IRQ_MASK:  mask_d            = csr_wdata[4:1];
        A_PERF_SNAP: snap_en           = 1'b1;
        default: ;
      endcase
    end
    sticky_d = (sticky_q & ~clr) |
               {start_err, rx_illegal_cmd, rx_crc_error, core_done_tile_pulse};
    if (csr_ren && !csr_wen) begin
      rvalid_d = 1'b1;
      rdata_d  = mapped ? rd_mux : 32'h0;
    end
  end

  // All architectural state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      irq_en_q   <= 1'b0;
      mask_q     <= '0;
      sticky_q   <= '0;
      uart_len_q <= '0;
      crc_en_q   <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      irq_en_q   <= irq_en_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      uart_len_q <= uart_len_d;
      crc_en_q   <= crc_en_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      irq_q      <= irq_d;
    end
  end

  assign csr_rdata    = rdata_q;
  assign csr_rvalid   = rvalid_q;
  assign csr_err      = err_q;
  assign start_pulse  = start_q;
  assign abort_pulse  = abort_q;
  assign irq          = irq_q;
  assign cfg_M        = active_q.m;
  assign cfg_N        = active_q.n;
  assign cfg_K        = active_q.k;
  assign cfg_Tm       = active_q.tm;
  assign cfg_Tn       = active_q.tn;
  assign cfg_Tk       = active_q.tk;
  assign cfg_m_idx    = active_q.m_idx;
  assign cfg_n_idx    = active_q.n_idx;
  assign cfg_k_idx    = active_q.k_idx;
  assign cfg_bank_sel = active_q.bank_sel;
  assign cfg_Sa       = active_q.sa;
  assign cfg_Sw       = active_q.sw;
  assign uart_len_max = uart_len_q;
  assign uart_crc_en  = crc_en_q;

endmodule
